// File: rtl/pc_sequencer.sv
// pc_sequencer
// ------------
// Fetch controller between the program counter, the instruction memory port
// and the execute/trap logic. It issues one fetch request per PC value,
// advances the PC by 4 on every completed fetch, and redirects the PC on a
// branch/jump or trap. A redirect that arrives while a fetch is waiting for
// its ack is parked in pend_addr and applied together with that ack. The
// sequencer stops fetching for good once the PC reports halt.
//
// Handshake (imem_req / imem_ack): imem_req is the valid and imem_ack is the
// ready. A transfer completes in a cycle where both are high. Once raised,
// imem_req and imem_addr stay stable until the transfer completes; only an
// asynchronous reset may withdraw a request.
//
// Ports
//   clk          core clock, rising edge
//   rstn         asynchronous active-low reset
//   instr_addr   current PC value
//   pc_halt      halt flag from the program counter
//   stall        back-end stall, blocks issuing the next fetch
//   imem_ack     instruction memory completed the current request
//   br_taken     single-cycle redirect request, target on br_target
//   br_target    redirect target
//   trap         single-cycle trap request, overrides br_taken
//   pc_we        PC write enable
//   pc_imm       PC loads pc_imm_addr (1) or PC+4 (0)
//   pc_imm_addr  PC load value, 0 whenever pc_imm is 0
//   imem_req     fetch request
//   imem_addr    fetch address, instr_addr while imem_req is high, else 0
//   fetch_valid  the acked instruction is architecturally valid
//   halted       sequencer is in HALTED
//   dbg_state    current FSM state (0 IDLE, 1 FETCH, 2 HALTED)
module pc_sequencer #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_addr,
    input  logic        pc_halt,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap,
    output logic        pc_we,
    output logic        pc_imm,
    output logic [31:0] pc_imm_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        fetch_valid,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic        pend_v;
    logic [31:0] pend_addr;

    // Redirect requested in this cycle (trap wins over branch).
    logic        now_v;
    logic [31:0] now_addr;
    // Redirect applied at an ack: this cycle's request first, then the parked one.
    logic        sel_v;
    logic [31:0] sel_addr;

    always_comb begin
        now_v    = trap | br_taken;
        now_addr = trap ? TRAP_VEC : br_target;
        sel_v    = now_v | pend_v;
        sel_addr = now_v ? now_addr : pend_addr;
    end

    // Outputs decode from the state and same-cycle inputs so that pc_we
    // coincides with the ack. Gating with rstn keeps every output at 0 for
    // the whole reset interval, including an IDLE redirect.
    always_comb begin
        pc_we       = 1'b0;
        pc_imm      = 1'b0;
        pc_imm_addr = 32'h0;
        imem_req    = 1'b0;
        imem_addr   = 32'h0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        if (rstn) begin
            case (state)
                IDLE: begin
                    // Nothing in flight, so a redirect is written straight into the PC.
                    if (now_v) begin
                        pc_we       = 1'b1;
                        pc_imm      = 1'b1;
                        pc_imm_addr = now_addr;
                    end
                end
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = instr_addr;
                    if (imem_ack) begin
                        pc_we = 1'b1;
                        if (sel_v) begin
                            // The word just fetched belongs to the old path: drop it.
                            pc_imm      = 1'b1;
                            pc_imm_addr = sel_addr;
                        end else begin
                            fetch_valid = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (now_v) begin
                        pend_v <= 1'b0;
                    end
                    if (pc_halt) begin
                        state <= HALTED;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        pend_v <= 1'b0;
                        if (pc_halt) begin
                            state <= HALTED;
                        end else if (stall) begin
                            state <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (now_v) begin
                        // Latest redirect wins; it is applied when the ack arrives.
                        pend_v    <= 1'b1;
                        pend_addr <= now_addr;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
